fir_ap_sequencer: RTL

//  AXI-Lite control front-end and run sequencer for the FIR engine. Holds the ap_ctrl

---
 rtl/fir_ctrl_pkg.sv | 29 ++
 rtl/fir_ap_sequencer_if.sv | 28 ++
 rtl/fir_tap_port_mux.sv | 22 ++
 rtl/fir_ap_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
// Shared constants, state encoding and status helpers for the FIR control front-end.
package fir_ctrl_pkg;

    localparam int unsigned ADDR_AP_CTRL  = 'h000;
    localparam int unsigned ADDR_DATA_LEN = 'h010;
    localparam int unsigned ADDR_TAP_BASE = 'h080;

    localparam int STAT_START = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_IDLE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } ap_state_e;

    // Host-visible {ap_idle, ap_done, ap_start}; the engine is idle again once it reports done.
    function automatic logic [2:0] status_bits(input ap_state_e s);
        logic [2:0] b;
        b             = '0;
        b[STAT_START] = (s == ST_START);
        b[STAT_DONE]  = (s == ST_DONE);
        b[STAT_IDLE]  = (s == ST_IDLE) || (s == ST_DONE);
        return b;
    endfunction

endpackage

// File: rtl/fir_ap_sequencer_if.sv
// AXI-Lite write/read channels (no B channel) between the host and the FIR control front-end.
interface fir_ap_sequencer_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [pADDR_WIDTH-1:0] awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [pDATA_WIDTH-1:0] wdata;
    logic                   arvalid;
    logic                   arready;
    logic [pADDR_WIDTH-1:0] araddr;
    logic                   rvalid;
    logic                   rready;
    logic [pDATA_WIDTH-1:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/fir_tap_port_mux.sv
// Selects who drives the single-port tap RAM: the engine during a run, the host otherwise.
module fir_tap_port_mux #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   eng_own,
    input  logic [pADDR_WIDTH-1:0] eng_tap_addr,
    input  logic [pADDR_WIDTH-1:0] host_addr,
    input  logic                   host_tap_we,
    input  logic [pDATA_WIDTH-1:0] host_wdata,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di
);
    always_comb begin
        tap_EN = 1'b1;
        tap_WE = (!eng_own && host_tap_we) ? 4'hF : 4'h0;
        tap_A  = eng_own ? eng_tap_addr : host_addr;
        tap_Di = host_wdata;
    end
endmodule

// File: rtl/fir_ap_sequencer.sv
// AXI-Lite control front-end and run sequencer for the FIR engine: ap_ctrl status,
// data_length register, engine launch and tap RAM arbitration.
module fir_ap_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    fir_ap_sequencer_if.slave      axil,
    output logic                   eng_start,
    input  logic                   eng_done,
    input  logic [pADDR_WIDTH-1:0] eng_tap_addr,
    output logic [pDATA_WIDTH-1:0] data_length,
    output logic                   tap_EN,
    output logic [3:0]             tap_WE,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do
);
    localparam logic [pADDR_WIDTH-1:0] A_CTRL   = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_LEN    = pADDR_WIDTH'(ADDR_DATA_LEN);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_LO = pADDR_WIDTH'(ADDR_TAP_BASE);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_HI = pADDR_WIDTH'(ADDR_TAP_BASE + 4 * (Tape_Num - 1));

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_TAP_LO) && (a <= A_TAP_HI);
    endfunction

    ap_state_e              state_q, state_d;
    logic                   host_own;
    logic                   wr_fire, rd_fire, rd_done, start_req;
    logic                   rvalid_q, rd_ram_q, rd_clr_q;
    logic [pDATA_WIDTH-1:0] rdata_q, data_len_q, rd_value;
    logic                   rd_from_ram, rd_clears;

    assign host_own  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign wr_fire   = axil.awvalid && axil.wvalid;
    assign rd_fire   = axil.arvalid && axil.arready;
    assign rd_done   = rvalid_q && axil.rready;
    assign start_req = wr_fire && (axil.awaddr == A_CTRL) && axil.wdata[0] && host_own;

    assign axil.awready = wr_fire;
    assign axil.wready  = wr_fire;
    assign axil.arready = !rvalid_q && !wr_fire;
    assign axil.rvalid  = rvalid_q;
    // A tap read returns RAM data live in its first valid cycle, then the captured copy.
    assign axil.rdata   = rd_ram_q ? tap_Do : rdata_q;
    assign data_length  = data_len_q;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        eng_start = 1'b0;
        case (state_q)
            ST_IDLE:  if (start_req) state_d = ST_START;
            ST_START: begin
                eng_start = 1'b1;
                state_d   = ST_BUSY;
            end
            ST_BUSY:  if (eng_done) state_d = ST_DONE;
            ST_DONE: begin
                if (start_req)               state_d = ST_START;
                else if (rd_done && rd_clr_q) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read decode; the status snapshot is taken at accept so a coincident eng_done is not seen.
    always_comb begin
        rd_value    = '0;
        rd_from_ram = 1'b0;
        rd_clears   = (axil.araddr == A_CTRL) && (state_q == ST_DONE);
        if (axil.araddr == A_CTRL) begin
            rd_value = {{(pDATA_WIDTH-3){1'b0}}, status_bits(state_q)};
        end else if (axil.araddr == A_LEN) begin
            rd_value = data_len_q;
        end else if (is_tap(axil.araddr)) begin
            rd_from_ram = host_own;
            rd_value    = host_own ? '0 : '1;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            rvalid_q   <= 1'b0;
            rd_ram_q   <= 1'b0;
            rd_clr_q   <= 1'b0;
            rdata_q    <= '0;
            data_len_q <= '0;
        end else begin
            if (wr_fire && (axil.awaddr == A_LEN) && host_own) data_len_q <= axil.wdata;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rd_ram_q <= rd_from_ram;
                rd_clr_q <= rd_clears;
                rdata_q  <= rd_value;
            end else begin
                if (rd_ram_q) begin
                    rdata_q  <= tap_Do;
                    rd_ram_q <= 1'b0;
                end
                if (rd_done) rvalid_q <= 1'b0;
            end
        end
    end

    fir_tap_port_mux #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_tap_mux (
        .eng_own      (!host_own),
        .eng_tap_addr (eng_tap_addr),
        .host_addr    (wr_fire ? axil.awaddr : axil.araddr),
        .host_tap_we  (wr_fire && is_tap(axil.awaddr)),
        .host_wdata   (axil.wdata),
        .tap_EN       (tap_EN),
        .tap_WE       (tap_WE),
        .tap_A        (tap_A),
        .tap_Di       (tap_Di)
    );
endmodule
